adc_channel_conditioner: RTL and testbench

ADC_CHANNEL_CONDITIONER -- requirements
Module: adc_channel_conditioner

---
 rtl/adc_pkg.sv | 12 +
 rtl/adc_cond_lane.sv | 103 ++++++++++
 rtl/adc_channel_conditioner.sv | 132 +++++++++++++
 tb/tb_adc_channel_conditioner.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared constants and control-state encoding for the ADC channel conditioner.
package adc_pkg;

  localparam int          COEF_FRAC_BITS = 16;
  localparam logic [17:0] UNITY_COEF     = 18'h10000;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } ctrl_state_e;

endpackage

// File: rtl/adc_cond_lane.sv
// One channel of the conditioner: gain, offset with saturation, block averaging.
module adc_cond_lane
  import adc_pkg::*;
#(
  parameter int ADC_CHDATA_SIZE = 16,
  parameter int ADC_CALIB_SIZE  = 18,
  parameter int DECIM_LOG2_MAX  = 4,
  parameter int SHIFT_W         = 3
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              cfg_load_i,
  input  logic signed [ADC_CALIB_SIZE-1:0]  mult_coef_i,
  input  logic signed [ADC_CALIB_SIZE-1:0]  add_coef_i,
  input  logic signed [ADC_CHDATA_SIZE-1:0] sample_i,
  input  logic                              s2_en_i,
  input  logic                              ovr_clear_i,
  input  logic                              acc_en_i,
  input  logic                              acc_last_i,
  input  logic [SHIFT_W-1:0]                shift_i,
  input  logic                              flush_i,
  output logic signed [ADC_CHDATA_SIZE-1:0] data_o,
  output logic                              overrange_o
);

  localparam int W    = ADC_CHDATA_SIZE;
  localparam int C    = ADC_CALIB_SIZE;
  localparam int PW   = W + C;
  localparam int S1W  = PW - COEF_FRAC_BITS;
  localparam int SUMW = S1W + C;
  localparam int AW   = W + DECIM_LOG2_MAX;

  localparam logic signed [SUMW-1:0] SAT_MAX = {{(SUMW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [SUMW-1:0] SAT_MIN = ~SAT_MAX;

  logic signed [C-1:0]    mult_sh_q, add_sh_q;
  logic signed [PW-1:0]   prod;
  logic signed [S1W-1:0]  s1_d, s1_q;
  logic signed [C-1:0]    add1_q;
  logic signed [SUMW-1:0] sum2;
  logic                   sat_hi, sat_lo;
  logic signed [W-1:0]    s2_d, s2_q;
  logic                   ovr_d, ovr_q;
  logic signed [AW-1:0]   acc_sum, acc_d, acc_q;
  logic signed [W-1:0]    data_d, data_q;

  // Offset travels with the sample so in-flight data keeps its original coefficients.
  always_comb begin
    prod   = sample_i * mult_sh_q;
    s1_d   = S1W'(prod >>> COEF_FRAC_BITS);
    sum2   = {{(SUMW-S1W){s1_q[S1W-1]}}, s1_q} + {{(SUMW-C){add1_q[C-1]}}, add1_q};
    sat_hi = sum2 > SAT_MAX;
    sat_lo = sum2 < SAT_MIN;
    s2_d   = W'(sum2);
    if (sat_hi) s2_d = W'(SAT_MAX);
    if (sat_lo) s2_d = W'(SAT_MIN);
    ovr_d  = (ovr_q & ~ovr_clear_i) | (s2_en_i & (sat_hi | sat_lo));
  end

  always_comb begin
    acc_sum = acc_q + {{(AW-W){s2_q[W-1]}}, s2_q};
    acc_d   = acc_q;
    data_d  = data_q;
    if (flush_i) begin
      acc_d = '0;
    end else if (acc_en_i) begin
      if (acc_last_i) begin
        acc_d  = '0;
        data_d = W'(acc_sum >>> shift_i);
      end else begin
        acc_d = acc_sum;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mult_sh_q <= C'(UNITY_COEF);
      add_sh_q  <= '0;
      s1_q      <= '0;
      add1_q    <= '0;
      s2_q      <= '0;
      ovr_q     <= 1'b0;
      acc_q     <= '0;
      data_q    <= '0;
    end else begin
      if (cfg_load_i) begin
        mult_sh_q <= mult_coef_i;
        add_sh_q  <= add_coef_i;
      end
      s1_q   <= s1_d;
      add1_q <= add_sh_q;
      s2_q   <= s2_d;
      ovr_q  <= ovr_d;
      acc_q  <= acc_d;
      data_q <= data_d;
    end
  end

  assign data_o      = data_q;
  assign overrange_o = ovr_q;

endmodule

// File: rtl/adc_channel_conditioner.sv
// Multi-channel ADC conditioner: control FSM, block counter and decimation latch
// feeding N identical calibration/averaging lanes.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   ST_IDLE | ADC not initialised: samples ignored, pipeline and sums flushed
//   ST_RUN  | samples accepted, calibrated and block-averaged
module adc_channel_conditioner
  import adc_pkg::*;
#(
  parameter int N_CHANNELS      = 2,
  parameter int ADC_CHDATA_SIZE = 16,
  parameter int ADC_CALIB_SIZE  = 18,
  parameter int DECIM_LOG2_MAX  = 4
) (
  input  logic                                     i_sys_clock,
  input  logic                                     i_reset,
  input  logic                                     i_init_done,
  input  logic                                     i_sample_valid,
  input  logic [N_CHANNELS*ADC_CHDATA_SIZE-1:0]    i_data,
  input  logic [N_CHANNELS*ADC_CALIB_SIZE-1:0]     i_mult_coef,
  input  logic [N_CHANNELS*ADC_CALIB_SIZE-1:0]     i_add_coef,
  input  logic                                     i_cfg_load,
  input  logic [$clog2(DECIM_LOG2_MAX+1)-1:0]      i_decim_log2,
  input  logic                                     i_ovr_clear,
  output logic [N_CHANNELS*ADC_CHDATA_SIZE-1:0]    o_data,
  output logic                                     o_valid,
  output logic [N_CHANNELS-1:0]                    o_overrange
);

  localparam int W  = ADC_CHDATA_SIZE;
  localparam int C  = ADC_CALIB_SIZE;
  localparam int DW = $clog2(DECIM_LOG2_MAX+1);
  localparam int CW = DECIM_LOG2_MAX + 1;

  logic [1:0]  rst_sync_q;
  logic        rst_n;
  ctrl_state_e state_q, state_d;
  logic        run, accept;
  logic [DW-1:0] d_req, d_blk, d_d, d_q;
  logic [CW-1:0] cnt_d, cnt_q, blk_end;
  logic        last_in;
  logic        v1_q, v2_q, last1_q, last2_q, valid_q;
  logic [DW-1:0] sh1_q, sh2_q;

  // Assertion is immediate; release is retimed so all flops leave reset together.
  always_ff @(posedge i_sys_clock or negedge i_reset) begin
    if (!i_reset) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (i_init_done)  state_d = ST_RUN;
      ST_RUN:  if (!i_init_done) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // The first sample of a block fixes its exponent; later samples reuse d_q.
  always_comb begin
    run     = (state_q == ST_RUN);
    accept  = run & i_sample_valid;
    d_req   = (i_decim_log2 > DW'(DECIM_LOG2_MAX)) ? DW'(DECIM_LOG2_MAX) : i_decim_log2;
    d_blk   = (cnt_q == '0) ? d_req : d_q;
    blk_end = (CW'(1) << d_blk) - CW'(1);
    last_in = (cnt_q == blk_end);
    cnt_d   = cnt_q;
    d_d     = d_q;
    if (!run) begin
      cnt_d = '0;
    end else if (accept) begin
      cnt_d = last_in ? '0 : cnt_q + CW'(1);
      d_d   = d_blk;
    end
  end

  always_ff @(posedge i_sys_clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      d_q     <= '0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      last1_q <= 1'b0;
      last2_q <= 1'b0;
      sh1_q   <= '0;
      sh2_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      v1_q    <= accept;
      v2_q    <= run & v1_q;
      last1_q <= accept & last_in;
      last2_q <= last1_q;
      sh1_q   <= d_blk;
      sh2_q   <= sh1_q;
      valid_q <= run & v2_q & last2_q;
    end
  end

  assign o_valid = valid_q;

  for (genvar k = 0; k < N_CHANNELS; k++) begin : g_lane
    adc_cond_lane #(
      .ADC_CHDATA_SIZE (W),
      .ADC_CALIB_SIZE  (C),
      .DECIM_LOG2_MAX  (DECIM_LOG2_MAX),
      .SHIFT_W         (DW)
    ) u_lane (
      .clk_i       (i_sys_clock),
      .rst_ni      (rst_n),
      .cfg_load_i  (i_cfg_load),
      .mult_coef_i (i_mult_coef[k*C +: C]),
      .add_coef_i  (i_add_coef[k*C +: C]),
      .sample_i    (i_data[k*W +: W]),
      .s2_en_i     (run & v1_q),
      .ovr_clear_i (i_ovr_clear),
      .acc_en_i    (run & v2_q),
      .acc_last_i  (last2_q),
      .shift_i     (sh2_q),
      .flush_i     (~run),
      .data_o      (o_data[k*W +: W]),
      .overrange_o (o_overrange[k])
    );
  end

endmodule

// File: tb/tb_adc_channel_conditioner.sv
// Scoreboard bench for adc_channel_conditioner: a behavioural model predicts each
// averaged output when the last sample of a block is driven.
module tb_adc_channel_conditioner;

  logic        clk = 1'b0;
  logic        i_reset, i_init_done, i_sample_valid, i_cfg_load, i_ovr_clear;
  logic [31:0] i_data;
  logic [35:0] i_mult_coef, i_add_coef;
  logic [2:0]  i_decim_log2;
  logic [31:0] o_data;
  logic        o_valid;
  logic [1:0]  o_overrange;

  logic signed [17:0] nxt_mult[2], nxt_add[2], mult_m[2], add_m[2];

  typedef struct {
    logic [31:0] data;
    int          cyc;
    bit          lat;
  } exp_t;
  exp_t exp_q[$];

  int    n_tests = 0, n_fail = 0, cyc = 0;
  int    blk_cnt = 0, blk_d = 0;
  int    blk_sum[2];
  string phase = "reset";

  assign i_mult_coef = {nxt_mult[1], nxt_mult[0]};
  assign i_add_coef  = {nxt_add[1], nxt_add[0]};

  adc_channel_conditioner dut (
    .i_sys_clock    (clk),
    .i_reset        (i_reset),
    .i_init_done    (i_init_done),
    .i_sample_valid (i_sample_valid),
    .i_data         (i_data),
    .i_mult_coef    (i_mult_coef),
    .i_add_coef     (i_add_coef),
    .i_cfg_load     (i_cfg_load),
    .i_decim_log2   (i_decim_log2),
    .i_ovr_clear    (i_ovr_clear),
    .o_data         (o_data),
    .o_valid        (o_valid),
    .o_overrange    (o_overrange)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got 0x%0h, expected 0x%0h", phase, tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (o_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_val("spurious_valid", 64'(o_valid), 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_val("data", 64'(o_data), 64'(e.data));
        if (e.lat) check_val("latency", 64'(cyc - e.cyc), 64'd3);
      end
    end
  end

  function automatic logic signed [15:0] lane_model(input int s, input logic signed [17:0] m,
                                                    input logic signed [17:0] a);
    longint p;
    p = (longint'(s) * longint'(m)) >>> 16;
    p = p + longint'(a);
    if (p > 32767)  p = 32767;
    if (p < -32768) p = -32768;
    return 16'(p);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset_block();
    blk_cnt    = 0;
    blk_sum[0] = 0;
    blk_sum[1] = 0;
  endtask

  // Drives one sample; with load=1 the coefficient pulse shares the cycle, so the
  // sample itself still sees the previous coefficients.
  task automatic send(input int s0, input int s1, input bit load = 1'b0);
    logic signed [15:0] y0, y1;
    int a0, a1;
    y0 = lane_model(s0, mult_m[0], add_m[0]);
    y1 = lane_model(s1, mult_m[1], add_m[1]);
    if (blk_cnt == 0) blk_d = (int'(i_decim_log2) > 4) ? 4 : int'(i_decim_log2);
    blk_sum[0] += int'(y0);
    blk_sum[1] += int'(y1);
    blk_cnt++;
    if (blk_cnt == (1 << blk_d)) begin
      a0 = blk_sum[0] >>> blk_d;
      a1 = blk_sum[1] >>> blk_d;
      exp_q.push_back('{data: {16'(a1), 16'(a0)}, cyc: cyc, lat: (blk_d == 0)});
      model_reset_block();
    end
    i_data         = {16'(s1), 16'(s0)};
    i_sample_valid = 1'b1;
    i_cfg_load     = load;
    if (load) begin
      mult_m = nxt_mult;
      add_m  = nxt_add;
    end
    tick();
    i_sample_valid = 1'b0;
    i_cfg_load     = 1'b0;
  endtask

  task automatic load_cfg();
    i_cfg_load = 1'b1;
    tick();
    i_cfg_load = 1'b0;
    mult_m = nxt_mult;
    add_m  = nxt_add;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      tick();
      n++;
    end
    check_val("drain", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    repeat (4) tick();
  endtask

  initial begin
    i_reset = 1'b0; i_init_done = 1'b0; i_sample_valid = 1'b0; i_cfg_load = 1'b0;
    i_ovr_clear = 1'b0; i_data = '0; i_decim_log2 = '0;
    nxt_mult = '{18'h10000, 18'h10000}; nxt_add = '{18'sd0, 18'sd0};
    mult_m = nxt_mult; add_m = nxt_add;
    model_reset_block();

    repeat (3) tick();
    check_val("valid", 64'(o_valid), 64'd0);
    check_val("data", 64'(o_data), 64'd0);
    check_val("ovr", 64'(o_overrange), 64'd0);
    i_reset = 1'b1;
    i_init_done = 1'b1;
    repeat (5) tick();

    phase = "unity";
    send(1000, -5);
    drain();
    send(1, 2);
    send(-32768, 32767);
    send(12345, -12345);
    send(0, -1);
    drain();

    phase = "gain";
    nxt_mult = '{18'h08000, 18'h18000}; nxt_add = '{-18'sd10, 18'sd7};
    load_cfg();
    send(-2001, 300);
    drain();
    nxt_mult = '{18'h10000, 18'h10000}; nxt_add = '{18'sd0, 18'sd0};
    send(500, 500, 1'b1);
    send(500, 500);
    drain();

    phase = "sat";
    nxt_mult = '{18'h1FFFF, 18'h10000};
    load_cfg();
    send(20000, 100);
    drain();
    check_val("ovr_pos", 64'(o_overrange), 64'd1);
    // 18'h20000 is -2.0 in signed Q1.16, so this drives the negative rail.
    nxt_mult = '{18'h20000, 18'h10000};
    load_cfg();
    send(20000, 0);
    drain();
    check_val("ovr_neg", 64'(o_overrange), 64'd1);
    i_ovr_clear = 1'b1;
    tick();
    i_ovr_clear = 1'b0;
    tick();
    check_val("ovr_clear", 64'(o_overrange), 64'd0);
    send(20000, 0);
    i_ovr_clear = 1'b1;
    tick();
    i_ovr_clear = 1'b0;
    drain();
    check_val("ovr_set_wins", 64'(o_overrange), 64'd1);

    phase = "decim";
    nxt_mult = '{18'h10000, 18'h10000}; nxt_add = '{18'sd0, 18'sd0};
    load_cfg();
    i_decim_log2 = 3'd2;
    send(1, -1); send(2, -2); send(3, -3); send(6, -3);
    drain();
    send(10, 0); send(20, 0);
    i_decim_log2 = 3'd1;
    tick();
    send(30, 0); send(40, 0);
    send(7, -8); tick(); send(8, -7);
    drain();
    i_decim_log2 = 3'd7;
    for (int k = 0; k < 16; k++) send(3 * k, -k);
    drain();

    phase = "initdrop";
    i_decim_log2 = 3'd2;
    send(100, 100); send(200, 200);
    tick();
    i_init_done = 1'b0;
    model_reset_block();
    repeat (6) tick();
    check_val("valid_idle", 64'(o_valid), 64'd0);
    i_init_done = 1'b1;
    repeat (3) tick();
    send(4, 4); send(8, 8); send(12, 12); send(16, 16);
    drain();

    phase = "reset";
    i_decim_log2 = 3'd0;
    nxt_mult = '{18'h08000, 18'h10000}; nxt_add = '{18'sd131071, 18'sd0};
    load_cfg();
    send(20000, 50);
    drain();
    check_val("ovr_pre", 64'(o_overrange), 64'd1);
    send(1000, 1000);
    send(1000, 1000);
    exp_q.delete();
    #2;
    i_reset = 1'b0;
    #1;
    check_val("async_valid", 64'(o_valid), 64'd0);
    check_val("async_data", 64'(o_data), 64'd0);
    check_val("async_ovr", 64'(o_overrange), 64'd0);
    mult_m = '{18'h10000, 18'h10000}; add_m = '{18'sd0, 18'sd0};
    model_reset_block();
    repeat (3) tick();
    check_val("held_data", 64'(o_data), 64'd0);
    i_reset = 1'b1;
    repeat (2) begin
      tick();
      check_val("release_valid", 64'(o_valid), 64'd0);
    end
    repeat (3) tick();
    send(1000, -1000);
    drain();
    check_val("post_ovr", 64'(o_overrange), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
